// File: rtl/link_tx_sched.sv
// SATA TX dword scheduler: picks ALIGN, transport data or the requested primitive
// for each PHY slot, with CONT suppression of repeated primitives.
module link_tx_sched #(
    parameter int unsigned ALIGN_PERIOD = 256,
    parameter logic [31:0] LFSR_SEED    = 32'hFFFFFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        phy_ready,
    input  logic [3:0]  prim_sel,
    input  logic        send_data,
    input  logic [31:0] data_in,
    input  logic        data_val_in,
    output logic        data_strobe_out,
    output logic [31:0] phy_data,
    output logic [3:0]  phy_charisk,
    output logic        align_slot,
    output logic        cont_active
);

    localparam int unsigned SLOT_W = $clog2(ALIGN_PERIOD);
    localparam int unsigned PRIM_W = 4;
    localparam int unsigned DW     = 32;

    localparam logic [DW-1:0] ALIGN_W   = 32'h7B4A4ABC;
    localparam logic [DW-1:0] CONT_W    = 32'h9999AA7C;
    localparam logic [DW-1:0] LFSR_MASK = 32'h80200003;
    localparam logic [3:0]    K_PRIM    = 4'b0001;
    localparam logic [3:0]    K_DATA    = 4'b0000;

    localparam logic [PRIM_W-1:0] P_SYNC = 4'd0;
    localparam logic [PRIM_W-1:0] P_HOLD = 4'd1;
    localparam logic [PRIM_W-1:0] P_SOF  = 4'd8;
    localparam logic [PRIM_W-1:0] P_EOF  = 4'd9;
    localparam logic [PRIM_W-1:0] P_DMAT = 4'd11;
    localparam logic [PRIM_W-1:0] P_NONE = 4'd15;

    // Repetition state of the current primitive run
    typedef enum logic [1:0] {
        REP_IDLE = 2'd0,
        REP_ONE  = 2'd1,
        REP_TWO  = 2'd2,
        REP_JUNK = 2'd3
    } rep_e;

    rep_e              rep_q, rep_n;
    logic [SLOT_W-1:0] slot_q, slot_n;
    logic [PRIM_W-1:0] last_q, last_n;
    logic [DW-1:0]     lfsr_q, lfsr_n;
    logic [DW-1:0]     data_n;
    logic [3:0]        k_n;
    logic              cont_n;
    logic [PRIM_W-1:0] eff_prim;

    function automatic logic [DW-1:0] prim_word(input logic [PRIM_W-1:0] p);
        case (p)
            4'd1:    prim_word = 32'hD5D5AA7C;
            4'd2:    prim_word = 32'h9595AA7C;
            4'd3:    prim_word = 32'h4A4A957C;
            4'd4:    prim_word = 32'h5555B57C;
            4'd5:    prim_word = 32'h3535B57C;
            4'd6:    prim_word = 32'h5656B57C;
            4'd7:    prim_word = 32'h5757B57C;
            4'd8:    prim_word = 32'h3737B57C;
            4'd9:    prim_word = 32'hD5D5B57C;
            4'd10:   prim_word = 32'h5858B57C;
            4'd11:   prim_word = 32'h3636B57C;
            default: prim_word = 32'hB5B5957C;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_q       <= REP_IDLE;
            slot_q      <= '0;
            last_q      <= P_NONE;
            lfsr_q      <= LFSR_SEED;
            phy_data    <= ALIGN_W;
            phy_charisk <= K_PRIM;
            cont_active <= 1'b0;
        end else begin
            rep_q       <= rep_n;
            slot_q      <= slot_n;
            last_q      <= last_n;
            lfsr_q      <= lfsr_n;
            phy_data    <= data_n;
            phy_charisk <= k_n;
            cont_active <= cont_n;
        end
    end

    always_comb begin
        rep_n           = rep_q;
        slot_n          = slot_q;
        last_n          = last_q;
        lfsr_n          = lfsr_q;
        data_n          = ALIGN_W;
        k_n             = K_PRIM;
        cont_n          = 1'b0;
        data_strobe_out = 1'b0;
        align_slot      = phy_ready && (slot_q < SLOT_W'(2));
        eff_prim        = send_data ? P_HOLD :
                          ((prim_sel > 4'd11) ? P_SYNC : prim_sel);

        if (!phy_ready || align_slot) begin
            slot_n = phy_ready ? slot_q + SLOT_W'(1) : '0;
            rep_n  = REP_IDLE;
            last_n = P_NONE;
        end else begin
            slot_n = slot_q + SLOT_W'(1);
            if (send_data && data_val_in) begin
                data_strobe_out = 1'b1;
                data_n          = data_in;
                k_n             = K_DATA;
                rep_n           = REP_IDLE;
                last_n          = P_NONE;
            end else if (eff_prim == P_SOF || eff_prim == P_EOF || eff_prim == P_DMAT) begin
                data_n = prim_word(eff_prim);
                rep_n  = REP_IDLE;
                last_n = P_NONE;
            end else if (eff_prim != last_q || rep_q == REP_IDLE) begin
                data_n = prim_word(eff_prim);
                rep_n  = REP_ONE;
                last_n = eff_prim;
            end else begin
                case (rep_q)
                    REP_ONE: begin
                        data_n = prim_word(eff_prim);
                        rep_n  = REP_TWO;
                    end
                    REP_TWO: begin
                        data_n = CONT_W;
                        cont_n = 1'b1;
                        rep_n  = REP_JUNK;
                    end
                    default: begin
                        // Junk fills the suppressed run; generator steps only here
                        data_n = lfsr_q;
                        k_n    = K_DATA;
                        cont_n = 1'b1;
                        lfsr_n = {1'b0, lfsr_q[DW-1:1]} ^ (lfsr_q[0] ? LFSR_MASK : '0);
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_link_tx_sched.sv
// Self-checking bench for link_tx_sched: directed plan steps plus random traffic
// compared against a run-length based reference model.
module tb_link_tx_sched;

    localparam int unsigned PERIOD = 16;
    localparam logic [31:0] SEED   = 32'hFFFFFFFF;
    localparam logic [31:0] ALIGN_W = 32'h7B4A4ABC;
    localparam logic [31:0] CONT_W  = 32'h9999AA7C;

    logic        clk = 1'b0;
    logic        rst;
    logic        phy_ready;
    logic [3:0]  prim_sel;
    logic        send_data;
    logic [31:0] data_in;
    logic        data_val_in;
    logic        data_strobe_out;
    logic [31:0] phy_data;
    logic [3:0]  phy_charisk;
    logic        align_slot;
    logic        cont_active;

    int checks = 0;
    int errors = 0;

    // reference model state
    int          m_slot;
    int          m_run_prim;
    int          m_run_len;
    logic [31:0] m_lfsr;
    logic        m_strobe;
    logic [31:0] prim_tab [12];
    logic [31:0] hist [32];

    link_tx_sched #(.ALIGN_PERIOD(PERIOD), .LFSR_SEED(SEED)) dut (
        .clk(clk), .rst(rst), .phy_ready(phy_ready), .prim_sel(prim_sel),
        .send_data(send_data), .data_in(data_in), .data_val_in(data_val_in),
        .data_strobe_out(data_strobe_out), .phy_data(phy_data),
        .phy_charisk(phy_charisk), .align_slot(align_slot), .cont_active(cont_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_slot     = 0;
        m_run_prim = -1;
        m_run_len  = 0;
        m_lfsr     = SEED;
    endtask

    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        logic [31:0] fb;
        fb = v[0] ? 32'h80200003 : 32'h0;
        return (v >> 1) ^ fb;
    endfunction

    // Drive one slot at posedge+1, check the combinational outputs, then the
    // registered dword after the next edge.
    task automatic step(input logic rdy, input logic sd, input logic dv,
                        input logic [3:0] ps, input logic [31:0] din);
        logic [31:0] e_d;
        logic [3:0]  e_k;
        logic        e_c, e_al;
        int          p;
        phy_ready   = rdy;
        send_data   = sd;
        data_val_in = dv;
        prim_sel    = ps;
        data_in     = din;
        e_d = ALIGN_W; e_k = 4'b0001; e_c = 1'b0; e_al = 1'b0; m_strobe = 1'b0;
        if (!rdy) begin
            m_slot = 0; m_run_prim = -1; m_run_len = 0;
        end else begin
            e_al   = (m_slot % PERIOD) < 2;
            m_slot = (m_slot + 1) % PERIOD;
            if (e_al) begin
                m_run_prim = -1; m_run_len = 0;
            end else if (sd && dv) begin
                m_strobe = 1'b1; e_d = din; e_k = 4'b0000;
                m_run_prim = -1; m_run_len = 0;
            end else begin
                p = sd ? 1 : ((int'(ps) < 12) ? int'(ps) : 0);
                if (p == 8 || p == 9 || p == 11) begin
                    e_d = prim_tab[p]; m_run_prim = -1; m_run_len = 0;
                end else begin
                    if (p == m_run_prim) m_run_len++;
                    else begin m_run_prim = p; m_run_len = 1; end
                    if (m_run_len <= 2) e_d = prim_tab[p];
                    else if (m_run_len == 3) begin e_d = CONT_W; e_c = 1'b1; end
                    else begin
                        e_d = m_lfsr; e_k = 4'b0000; e_c = 1'b1;
                        m_lfsr = lfsr_next(m_lfsr);
                    end
                end
            end
        end
        #1;
        check("strobe", 32'(data_strobe_out), 32'(m_strobe));
        check("align_slot", 32'(align_slot), 32'(e_al));
        @(posedge clk);
        #1;
        check("phy_data", phy_data, e_d);
        check("charisk", 32'(phy_charisk), 32'(e_k));
        check("cont_active", 32'(cont_active), 32'(e_c));
    endtask

    initial begin
        int          dcnt;
        logic [3:0]  ps;
        prim_tab = '{32'hB5B5957C, 32'hD5D5AA7C, 32'h9595AA7C, 32'h4A4A957C,
                     32'h5555B57C, 32'h3535B57C, 32'h5656B57C, 32'h5757B57C,
                     32'h3737B57C, 32'hD5D5B57C, 32'h5858B57C, 32'h3636B57C};
        rst = 1'b1; phy_ready = 1'b0; prim_sel = 4'd0; send_data = 1'b0;
        data_in = 32'h0; data_val_in = 1'b0;
        model_reset();

        // reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_data", phy_data, ALIGN_W);
        check("rst_k", 32'(phy_charisk), 32'h1);
        check("rst_cont", 32'(cont_active), 32'h0);
        check("rst_strobe", 32'(data_strobe_out), 32'h0);
        check("rst_align", 32'(align_slot), 32'h0);
        rst = 1'b0;

        // plan 1: SYNC run with ALIGN period 16
        for (int i = 0; i < 21; i++) begin
            step(1'b1, 1'b0, 1'b0, 4'd0, 32'h0);
            hist[i] = phy_data;
        end
        check("p1_slot0", hist[0], ALIGN_W);
        check("p1_slot2", hist[2], 32'hB5B5957C);
        check("p1_slot4", hist[4], CONT_W);
        check("p1_junk0", hist[5], 32'hFFFFFFFF);
        check("p1_junk1", hist[6], 32'hFFDFFFFC);
        check("p1_slot16", hist[16], ALIGN_W);
        check("p1_slot20", hist[20], CONT_W);

        // plan 2: continuous data 1..20 across an ALIGN pair
        dcnt = 1;
        while (dcnt <= 20) begin
            step(1'b1, 1'b1, 1'b1, 4'd0, 32'(dcnt));
            if (m_strobe) dcnt++;
        end

        // plan 3: valid drops for 5 slots mid-frame
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 4'd0, 32'hDEAD0000);
        step(1'b1, 1'b1, 1'b1, 4'd0, 32'h00000015);

        // plan 4: R_IP / R_OK alternating every 2 slots
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0, ((i / 2) % 2 == 0) ? 4'd4 : 4'd5, 32'h0);

        // plan 5: EOF held
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 4'd9, 32'h0);

        // random traffic, sticky primitive selection so runs form
        ps = 4'd0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) ps = 4'($urandom_range(0, 13));
            step($urandom_range(0, 31) != 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 1) == 1, ps, $urandom);
        end

        // plan 6: reset pulsed in the middle of junk
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 4'd3, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_data", phy_data, ALIGN_W);
        check("midrst_k", 32'(phy_charisk), 32'h1);
        check("midrst_cont", 32'(cont_active), 32'h0);
        phy_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        step(1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 1'b0, 1'b0, 4'd0, 32'h0);
            hist[i] = phy_data;
        end
        check("p6_align0", hist[0], ALIGN_W);
        check("p6_align1", hist[1], ALIGN_W);
        check("p6_cont", hist[4], CONT_W);
        check("p6_seed", hist[5], 32'hFFFFFFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
